// File: rtl/rgb2luma_pipe_pkg.sv
// luma_pkg: mode encodings, Q0.8 coefficient sets and fixed-point constants for rgb2luma_pipe
package luma_pkg;
  typedef enum logic [1:0] {
    MODE_BT601 = 2'd0,
    MODE_BT709 = 2'd1,
    MODE_AVG   = 2'd2,
    MODE_GREEN = 2'd3
  } mode_e;
  localparam int FRAC_W  = 8;
  localparam int COEF_W  = 9;
  localparam int ROUND_C = 128;
  localparam logic [COEF_W-1:0] C601_R = 9'd77;
  localparam logic [COEF_W-1:0] C601_G = 9'd150;
  localparam logic [COEF_W-1:0] C601_B = 9'd29;
  localparam logic [COEF_W-1:0] C709_R = 9'd54;
  localparam logic [COEF_W-1:0] C709_G = 9'd183;
  localparam logic [COEF_W-1:0] C709_B = 9'd19;
  localparam logic [COEF_W-1:0] CAVG_R = 9'd85;
  localparam logic [COEF_W-1:0] CAVG_G = 9'd85;
  localparam logic [COEF_W-1:0] CAVG_B = 9'd86;
  localparam logic [COEF_W-1:0] CGRN_R = 9'd0;
  localparam logic [COEF_W-1:0] CGRN_G = 9'd256;
  localparam logic [COEF_W-1:0] CGRN_B = 9'd0;
endpackage

// File: rtl/rgb2luma_pipe_if.sv
// rgb2luma_pipe_if: pixel-in / luma-out valid-ready stream bundle
interface rgb2luma_pipe_if #(parameter int PIX_W = 8);
  logic             s_valid_i;
  logic             s_ready_o;
  logic [PIX_W-1:0] s_red_i;
  logic [PIX_W-1:0] s_green_i;
  logic [PIX_W-1:0] s_blue_i;
  logic [1:0]       s_mode_i;
  logic             s_sof_i;
  logic             s_eol_i;
  logic             m_valid_o;
  logic             m_ready_i;
  logic [PIX_W-1:0] m_luma_o;
  logic             m_sof_o;
  logic             m_eol_o;
  modport slave (
    input  s_valid_i, s_red_i, s_green_i, s_blue_i, s_mode_i, s_sof_i, s_eol_i, m_ready_i,
    output s_ready_o, m_valid_o, m_luma_o, m_sof_o, m_eol_o
  );
  modport master (
    output s_valid_i, s_red_i, s_green_i, s_blue_i, s_mode_i, s_sof_i, s_eol_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_luma_o, m_sof_o, m_eol_o
  );
endinterface

// File: rtl/luma_coef_rom.sv
// luma_coef_rom: maps a 2-bit mode to its R/G/B luma coefficients
module luma_coef_rom
  import luma_pkg::*;
(
  input  logic [1:0]        mode,
  output logic [COEF_W-1:0] cr,
  output logic [COEF_W-1:0] cg,
  output logic [COEF_W-1:0] cb
);
  always_comb begin
    cr = mode == MODE_BT601 ? C601_R : mode == MODE_BT709 ? C709_R : mode == MODE_AVG ? CAVG_R : CGRN_R;
    cg = mode == MODE_BT601 ? C601_G : mode == MODE_BT709 ? C709_G : mode == MODE_AVG ? CAVG_G : CGRN_G;
    cb = mode == MODE_BT601 ? C601_B : mode == MODE_BT709 ? C709_B : mode == MODE_AVG ? CAVG_B : CGRN_B;
  end
endmodule

// File: rtl/rgb2luma_pipe.sv
// rgb2luma_pipe: 3-stage RGB-to-luma converter with per-pixel mode, markers, backpressure and frame counter
module rgb2luma_pipe
  import luma_pkg::*;
#(
  parameter int PIX_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  rgb2luma_pipe_if.slave   bus,
  output logic [CNT_W-1:0] frame_cnt_o
);
  localparam int PW = PIX_W + COEF_W;
  localparam int SW = PW + 2;
  localparam int YW = SW - FRAC_W;
  logic              en, ld1, ld2, ld3;
  logic              v1_d, v1_q, v2_d, v2_q, m_valid_d, m_valid_q;
  logic [PIX_W-1:0]  red1_d, red1_q, green1_d, green1_q, blue1_d, blue1_q;
  logic [1:0]        mode1_d, mode1_q;
  logic              sof1_d, sof1_q, eol1_d, eol1_q;
  logic [COEF_W-1:0] cr, cg, cb;
  logic [PW-1:0]     pr2_d, pr2_q, pg2_d, pg2_q, pb2_d, pb2_q;
  logic              sof2_d, sof2_q, eol2_d, eol2_q;
  logic [SW-1:0]     sum;
  logic [YW-1:0]     y;
  logic [PIX_W-1:0]  luma_d, luma_q;
  logic              m_sof_d, m_sof_q, m_eol_d, m_eol_q;
  logic [CNT_W-1:0]  frame_cnt_d, frame_cnt_q;
  luma_coef_rom u_rom (.mode(mode1_q), .cr(cr), .cg(cg), .cb(cb));
  always_comb begin
    en          = !m_valid_q || bus.m_ready_i;
    ld1         = en && bus.s_valid_i;
    ld2         = en && v1_q;
    ld3         = en && v2_q;
    v1_d        = en ? bus.s_valid_i : v1_q;
    v2_d        = en ? v1_q : v2_q;
    m_valid_d   = en ? v2_q : m_valid_q;
    red1_d      = ld1 ? bus.s_red_i : red1_q;
    green1_d    = ld1 ? bus.s_green_i : green1_q;
    blue1_d     = ld1 ? bus.s_blue_i : blue1_q;
    mode1_d     = ld1 ? bus.s_mode_i : mode1_q;
    sof1_d      = ld1 ? bus.s_sof_i : sof1_q;
    eol1_d      = ld1 ? bus.s_eol_i : eol1_q;
    pr2_d       = ld2 ? PW'(red1_q) * PW'(cr) : pr2_q;
    pg2_d       = ld2 ? PW'(green1_q) * PW'(cg) : pg2_q;
    pb2_d       = ld2 ? PW'(blue1_q) * PW'(cb) : pb2_q;
    sof2_d      = ld2 ? sof1_q : sof2_q;
    eol2_d      = ld2 ? eol1_q : eol2_q;
    sum         = SW'(pr2_q) + SW'(pg2_q) + SW'(pb2_q) + SW'(ROUND_C);
    y           = YW'(sum >> FRAC_W);
    luma_d      = ld3 ? (|y[YW-1:PIX_W] ? {PIX_W{1'b1}} : y[PIX_W-1:0]) : luma_q;
    m_sof_d     = ld3 ? sof2_q : m_sof_q;
    m_eol_d     = ld3 ? eol2_q : m_eol_q;
    frame_cnt_d = m_valid_q && bus.m_ready_i && m_sof_q ? frame_cnt_q + CNT_W'(1) : frame_cnt_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      m_valid_q   <= 1'b0;
      luma_q      <= '0;
      m_sof_q     <= 1'b0;
      m_eol_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      v1_q        <= v1_d;
      v2_q        <= v2_d;
      m_valid_q   <= m_valid_d;
      luma_q      <= luma_d;
      m_sof_q     <= m_sof_d;
      m_eol_q     <= m_eol_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    red1_q   <= red1_d;
    green1_q <= green1_d;
    blue1_q  <= blue1_d;
    mode1_q  <= mode1_d;
    sof1_q   <= sof1_d;
    eol1_q   <= eol1_d;
    pr2_q    <= pr2_d;
    pg2_q    <= pg2_d;
    pb2_q    <= pb2_d;
    sof2_q   <= sof2_d;
    eol2_q   <= eol2_d;
  end
  assign bus.s_ready_o = en;
  assign bus.m_valid_o = m_valid_q;
  assign bus.m_luma_o  = luma_q;
  assign bus.m_sof_o   = m_sof_q;
  assign bus.m_eol_o   = m_eol_q;
  assign frame_cnt_o   = frame_cnt_q;
endmodule
